// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 receiver keeping the last two scan-code bytes as {previous, latest}
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] key,
  output logic        key_valid,
  output logic        frame_err
);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          fclk_q, fclk_d, fclk_p_q;
  logic [7:0]    run_q, run_d;
  state_t        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          par_q, par_d;
  logic [WW-1:0] wd_q, wd_d;
  logic [15:0]   key_q, key_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic          fall, din, differ, flip, ok, expire;
  assign din       = dat_sync_q[1];
  assign differ    = clk_sync_q[1] != fclk_q;
  assign flip      = differ && run_q == 8'(FILTER_LEN - 1);
  assign fall      = fclk_p_q & ~fclk_q;
  assign ok        = (^{sr_q, par_q}) & din;
  assign expire    = state_q != IDLE && wd_q == WW'(TIMEOUT_CYCLES);
  assign key       = key_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;
  always_comb begin
    run_d     = differ && !flip ? run_q + 8'd1 : 8'd0;
    fclk_d    = flip ? ~fclk_q : fclk_q;
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    par_d     = par_q;
    key_d     = key_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    wd_d      = state_q == IDLE || fall || expire ? '0 : wd_q + 1'b1;
    if (fall) begin
      case (state_q)
        IDLE: begin
          state_d   = din ? IDLE : DATA;
          bit_cnt_d = 3'd0;
        end
        DATA: begin
          sr_d      = {din, sr_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = bit_cnt_q == 3'd7 ? PARITY : DATA;
        end
        PARITY: begin
          par_d   = din;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          key_d   = ok ? {key_q[7:0], sr_q} : key_q;
          valid_d = ok;
          err_d   = !ok;
        end
      endcase
    end else if (expire) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      fclk_q     <= 1'b1;
      fclk_p_q   <= 1'b1;
      run_q      <= '0;
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sr_q       <= '0;
      par_q      <= 1'b0;
      wd_q       <= '0;
      key_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      fclk_q     <= fclk_d;
      fclk_p_q   <= fclk_q;
      run_q      <= run_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sr_q       <= sr_d;
      par_q      <= par_d;
      wd_q       <= wd_d;
      key_q      <= key_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end
endmodule
